// File: rtl/code_match_game.sv
// Multi-round code-matching reflex game. An LFSR deals a secret code each round;
// debounced button presses toggle bits to cancel it, and won rounds are scored.
module code_match_game #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] TAPS          = 8'hB8,
  parameter logic [WIDTH-1:0] SEED          = WIDTH'(1),
  parameter int               PLAY_CYCLES   = 199,
  parameter int               RESULT_CYCLES = 10,
  parameter int               DEBOUNCE      = 4,
  parameter int               ROUNDS        = 4,
  parameter int               SCORE_W       = 4
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    submit,
  input  logic [WIDTH-1:0]        buttons,
  output logic [WIDTH-1:0]        lights,
  output logic                    correct_light,
  output logic                    incorrect_light,
  output logic                    busy,
  output logic                    game_over,
  output logic [$clog2(ROUNDS):0] round_idx,
  output logic [SCORE_W-1:0]      score
);

  localparam int TMAX    = (PLAY_CYCLES > RESULT_CYCLES) ? PLAY_CYCLES : RESULT_CYCLES;
  localparam int TIMER_W = $clog2(TMAX) + 1;
  localparam int DB_W    = $clog2(DEBOUNCE) + 1;
  localparam int RIDX_W  = $clog2(ROUNDS) + 1;

  localparam logic [WIDTH-1:0]   SEED_EFF    = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [TIMER_W-1:0] PLAY_LAST   = TIMER_W'(PLAY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RESULT_LAST = TIMER_W'(RESULT_CYCLES - 1);
  localparam logic [DB_W-1:0]    DB_LAST     = DB_W'(DEBOUNCE - 1);
  localparam logic [RIDX_W-1:0]  ROUND_LAST  = RIDX_W'(ROUNDS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, RESULT, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   lfsr, code, toggle, filt;
  logic [WIDTH-1:0]   filt_next, toggle_next;
  logic [DB_W-1:0]    db_cnt      [WIDTH];
  logic [DB_W-1:0]    db_cnt_next [WIDTH];
  logic [TIMER_W-1:0] timer;
  logic               play_exit, result_done, last_round, match_next;

  assign play_exit   = submit || (timer == PLAY_LAST);
  assign result_done = (timer == RESULT_LAST);
  assign last_round  = (round_idx == ROUND_LAST);

  // Per-bit debounce: a bit's filtered level follows the raw level only after
  // DEBOUNCE consecutive differing samples; a rising filtered edge flips its toggle.
  always_comb begin
    // NOTE: every comb output gets a default before any branch, so no latch is inferred.
    filt_next   = filt;
    toggle_next = toggle;
    for (int i = 0; i < WIDTH; i++) begin
      db_cnt_next[i] = '0;
      if (buttons[i] != filt[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          filt_next[i] = buttons[i];
          if (buttons[i]) toggle_next[i] = ~toggle[i];
        end else begin
          db_cnt_next[i] = db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // A toggle edge in the exit cycle still counts toward the match.
  assign match_next = ((code ^ toggle_next) == '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start)       state_next = LOAD;
      LOAD:                        state_next = PLAY;
      PLAY:       if (play_exit)   state_next = RESULT;
      RESULT:     if (result_done) state_next = last_round ? DONE : LOAD;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      lfsr            <= SEED_EFF;
      code            <= '0;
      toggle          <= '0;
      filt            <= '0;
      timer           <= '0;
      lights          <= '0;
      correct_light   <= 1'b0;
      incorrect_light <= 1'b0;
      busy            <= 1'b0;
      game_over       <= 1'b0;
      round_idx       <= '0;
      score           <= '0;
      // NOTE: db_cnt is a tiny per-bit register bank, not a RAM, so it is reset like any flop.
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values.
      state     <= state_next;
      lfsr      <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
      busy      <= state_next inside {LOAD, PLAY, RESULT};
      game_over <= (state_next == DONE);

      case (state)
        IDLE, DONE: begin
          lights <= '0;
          if (start) begin
            score     <= '0;
            round_idx <= '0;
          end
        end
        LOAD: begin
          code   <= lfsr;
          toggle <= '0;
          filt   <= '0;
          timer  <= '0;
          lights <= '0;
          for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
        end
        PLAY: begin
          toggle <= toggle_next;
          filt   <= filt_next;
          db_cnt <= db_cnt_next;
          lights <= code ^ toggle;
          if (play_exit) begin
            timer           <= '0;
            correct_light   <= match_next;
            incorrect_light <= !match_next;
            if (match_next && (score != SCORE_MAX)) score <= score + SCORE_W'(1);
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        RESULT: begin
          lights <= (result_done && last_round) ? '0 : (code ^ toggle);
          if (result_done) begin
            timer           <= '0;
            correct_light   <= 1'b0;
            incorrect_light <= 1'b0;
            if (!last_round) round_idx <= round_idx + RIDX_W'(1);
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: lights <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_code_match_game.sv
// Randomised self-checking bench for code_match_game: a default-parameter game and a
// 5-round / 2-bit-score game, both checked cycle by cycle against a round-level model.
module tb_code_match_game;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h01;
  localparam int DB   = 4;
  localparam int PC_A = 199, RC_A = 10, RN_A = 4, SW_A = 4;
  localparam int PC_B = 30,  RC_B = 3,  RN_B = 5, SW_B = 2;

  logic       clock   = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       submit  = 1'b0;
  logic [7:0] buttons = '0;

  logic [7:0] lights_a, lights_b;
  logic       correct_a, incorrect_a, busy_a, game_over_a;
  logic       correct_b, incorrect_b, busy_b, game_over_b;
  logic [2:0] round_a;
  logic [3:0] round_b;
  logic [3:0] score_a;
  logic [1:0] score_b;

  code_match_game u_a (
    .clock(clock), .rst_n(rst_n), .start(start_a), .submit(submit), .buttons(buttons),
    .lights(lights_a), .correct_light(correct_a), .incorrect_light(incorrect_a),
    .busy(busy_a), .game_over(game_over_a), .round_idx(round_a), .score(score_a)
  );

  code_match_game #(
    .PLAY_CYCLES(PC_B), .RESULT_CYCLES(RC_B), .ROUNDS(RN_B), .SCORE_W(SW_B)
  ) u_b (
    .clock(clock), .rst_n(rst_n), .start(start_b), .submit(submit), .buttons(buttons),
    .lights(lights_b), .correct_light(correct_b), .incorrect_light(incorrect_b),
    .busy(busy_b), .game_over(game_over_b), .round_idx(round_b), .score(score_b)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  bit sel      = 1'b0;
  int score_m  = 0;
  int round_m  = 0;

  logic [31:0] o_lights, o_correct, o_incorrect, o_busy, o_over, o_round, o_score;

  always_comb begin
    o_lights    = sel ? 32'(lights_b)    : 32'(lights_a);
    o_correct   = sel ? 32'(correct_b)   : 32'(correct_a);
    o_incorrect = sel ? 32'(incorrect_b) : 32'(incorrect_a);
    o_busy      = sel ? 32'(busy_b)      : 32'(busy_a);
    o_over      = sel ? 32'(game_over_b) : 32'(game_over_a);
    o_round     = sel ? 32'(round_b)     : 32'(round_a);
    o_score     = sel ? 32'(score_b)     : 32'(score_a);
  end

  // Number of LFSR steps since reset release.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v = SEED;
    for (int k = 0; k < n; k++) v = {v[6:0], ^(v & TAPS)};
    return v;
  endfunction

  // Call at a negedge while the selected game sits in IDLE or DONE; returns in LOAD.
  task automatic start_game();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    score_m = 0;
    round_m = 0;
    check("start_busy",  o_busy,  32'(1));
    check("start_over",  o_over,  32'(0));
    check("start_score", o_score, 32'(0));
    check("start_round", o_round, 32'(0));
  endtask

  // Call at the negedge of a LOAD cycle. mode: 0 idle, 1 hold code then release,
  // 2 glitch on bit 0, 3 random press waveform.
  task automatic play_round(input int mode, input int n_play, input bit do_submit);
    logic [7:0] btn [0:255];
    logic [7:0] tog [0:255];
    logic [7:0] code_m, exp_l, prev_tog;
    logic       prev_l0;
    bit         match, ok, f, tg;
    int         rc, rounds, smax, flips, tl, lvl, len, t;

    rc     = sel ? RC_B : RC_A;
    rounds = sel ? RN_B : RN_A;
    smax   = sel ? ((1 << SW_B) - 1) : ((1 << SW_A) - 1);
    code_m = lfsr_at(cyc);
    flips  = 0;
    prev_l0 = 1'b0;

    for (int i = 0; i < 256; i++) btn[i] = '0;
    for (int i = 0; i < n_play; i++) begin
      case (mode)
        1:       btn[i] = (i < 6) ? code_m : 8'h00;
        2:       btn[i] = ((i >= 2 && i <= 4) || (i >= 12 && i <= 15)) ? 8'h01 : 8'h00;
        default: btn[i] = 8'h00;
      endcase
    end
    if (mode == 3) begin
      for (int b = 0; b < 8; b++) begin
        t   = 0;
        lvl = int'($urandom_range(1, 0));
        while (t < n_play) begin
          len = int'($urandom_range(8, 1));
          for (int k = 0; k < len && t < n_play; k++) begin
            btn[t][b] = lvl[0];
            t++;
          end
          lvl = 1 - lvl;
        end
      end
    end

    // Reference: a bit's filtered level changes once the last DB samples, all taken
    // after its previous change, disagree with it; each rise flips that bit's toggle.
    for (int b = 0; b < 8; b++) begin
      f  = 1'b0;
      tg = 1'b0;
      tl = -1;
      for (int i = 0; i < n_play; i++) begin
        ok = (i - DB + 1) > tl;
        if (ok) for (int k = 0; k < DB; k++) if (btn[i-k][b] == f) ok = 1'b0;
        if (ok) begin
          f  = !f;
          tl = i;
          if (f) tg = !tg;
        end
        tog[i][b] = tg;
      end
    end

    @(posedge clock);
    for (int i = 0; i < n_play; i++) begin
      @(negedge clock);
      buttons = btn[i];
      submit  = do_submit && (i == n_play - 1);
      if (sel) start_b = 1'($urandom); else start_a = 1'($urandom);
      prev_tog = (i >= 2) ? tog[i-2] : 8'h00;
      exp_l    = (i == 0) ? 8'h00 : (code_m ^ prev_tog);
      check("play_lights",    o_lights,    32'(exp_l));
      check("play_correct",   o_correct,   32'(0));
      check("play_incorrect", o_incorrect, 32'(0));
      check("play_busy",      o_busy,      32'(1));
      check("play_score",     o_score,     32'(score_m));
      check("play_round",     o_round,     32'(round_m));
      if (mode == 2 && i >= 1) begin
        if (i > 1 && o_lights[0] != prev_l0) flips++;
        prev_l0 = o_lights[0];
      end
    end
    if (mode == 2) check("glitch_flips", 32'(flips), 32'(1));

    match = ((code_m ^ tog[n_play-1]) == 8'h00);
    if (match && score_m < smax) score_m++;
    for (int r = 0; r < rc; r++) begin
      @(negedge clock);
      buttons = 8'($urandom);
      submit  = 1'($urandom);
      start_a = 1'b0;
      start_b = 1'b0;
      prev_tog = (n_play >= 2) ? tog[n_play-2] : 8'h00;
      exp_l    = (r == 0) ? (code_m ^ prev_tog) : (code_m ^ tog[n_play-1]);
      check("res_lights",    o_lights,    32'(exp_l));
      check("res_correct",   o_correct,   32'(match));
      check("res_incorrect", o_incorrect, 32'(!match));
      check("res_score",     o_score,     32'(score_m));
      check("res_round",     o_round,     32'(round_m));
      check("res_busy",      o_busy,      32'(1));
    end

    @(negedge clock);
    buttons = '0;
    submit  = 1'b0;
    check("post_correct",   o_correct,   32'(0));
    check("post_incorrect", o_incorrect, 32'(0));
    check("post_score",     o_score,     32'(score_m));
    if (round_m == rounds - 1) begin
      check("done_over",   o_over,   32'(1));
      check("done_busy",   o_busy,   32'(0));
      check("done_lights", o_lights, 32'(0));
      check("done_round",  o_round,  32'(round_m));
    end else begin
      round_m++;
      check("next_busy",  o_busy,  32'(1));
      check("next_over",  o_over,  32'(0));
      check("next_round", o_round, 32'(round_m));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n;
    bit          ds;
    logic [7:0]  code_m;
    int          exp_sc [5] = '{1, 2, 3, 3, 3};

    #12;
    check("rst_lights_a", 32'(lights_a), 32'(0));
    check("rst_flags_a",  32'({correct_a, incorrect_a, busy_a, game_over_a}), 32'(0));
    check("rst_round_a",  32'(round_a), 32'(0));
    check("rst_score_a",  32'(score_a), 32'(0));
    check("rst_flags_b",  32'({correct_b, incorrect_b, busy_b, game_over_b}), 32'(0));
    check("rst_lfsr",     32'(u_a.lfsr), 32'(SEED));
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_busy", o_busy, 32'(0));

    // Game A1: idle timeout, clean win, glitch filter, submit on the timeout cycle.
    start_game();
    play_round(0, PC_A, 1'b0);
    play_round(1, 13, 1'b1);
    play_round(2, 24, 1'b1);
    play_round(3, PC_A, 1'b1);

    // Game A2 restarted from DONE with random presses.
    start_game();
    for (int k = 0; k < 4; k++) begin
      n  = ($urandom_range(2, 0) == 0) ? PC_A : int'($urandom_range(60, 5));
      ds = (n < PC_A) ? 1'b1 : 1'($urandom);
      play_round(3, n, ds);
    end

    // Asynchronous reset in the middle of PLAY.
    start_game();
    code_m = lfsr_at(cyc);
    @(posedge clock);
    repeat (6) @(negedge clock);
    check("pre_rst_lights", o_lights, 32'(code_m));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_lights", o_lights, 32'(0));
    check("mid_rst_flags",  32'({correct_a, incorrect_a, busy_a, game_over_a}), 32'(0));
    check("mid_rst_round",  o_round, 32'(0));
    check("mid_rst_score",  o_score, 32'(0));
    check("mid_rst_lfsr",   32'(u_a.lfsr), 32'(SEED));
    @(negedge clock);
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst_idle", o_busy, 32'(0));
    start_game();
    play_round(3, 20, 1'b1);
    #2 rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    // Game B: every round won, score saturates at 3, then restart from DONE.
    sel = 1'b1;
    start_game();
    for (int k = 0; k < RN_B; k++) begin
      play_round(1, 13, 1'b1);
      check("b_score_seq", o_score, 32'(exp_sc[k]));
    end
    check("b_game_over", o_over, 32'(1));
    start_game();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
